// File: rtl/e10_avl_st_pkt_gen.sv
// e10 loopback packet generator: CSR-programmed Ethernet frame source on a
// 64-bit Avalon-ST TX stream (FCS is appended downstream by the MAC).
// Frame: word0 = {DA, SA[47:32]}, word1 = {SA[31:0], LEN, SEQ}, then payload
// bytes k ^ SEED, zero-padded in the eop beat.
module e10_avl_st_pkt_gen #(
  parameter int         IPG_CYCLES = 2,
  parameter int         MAX_LEN    = 1500,
  parameter logic [7:0] SEED       = 8'h5A
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [7:0]  avalon_mm_address,
  input  logic        avalon_mm_write,
  input  logic        avalon_mm_read,
  input  logic [31:0] avalon_mm_writedata,
  output logic [31:0] avalon_mm_readdata,
  output logic        avalon_mm_waitrequest,
  output logic [63:0] avalon_st_tx_data,
  output logic        avalon_st_tx_valid,
  output logic        avalon_st_tx_sop,
  output logic        avalon_st_tx_eop,
  output logic [2:0]  avalon_st_tx_empty,
  output logic        avalon_st_tx_error,
  input  logic        avalon_st_tx_ready,
  output logic        gen_active,
  output logic        gen_done
);

  typedef enum logic [2:0] {S_DONE, S_IDLE, S_SOP, S_HDR1, S_PLD, S_IPG} state_t;

  localparam logic [15:0] MIN_LEN_C = 16'd46;
  localparam logic [15:0] MAX_LEN_C = 16'(MAX_LEN);
  localparam logic [15:0] IPG_LAST  = 16'(IPG_CYCLES - 1);

  // CSR storage
  logic [31:0] da_lo, sa_lo, pkt_numb, pkt_sent;
  logic [15:0] da_hi, sa_hi, pkt_len;
  logic        ctrl_cont, ctrl_start, ctrl_stop;
  logic        strobe_d;
  logic [31:0] csr_rd;

  // Generator state
  state_t      state;
  logic [15:0] seq, len_reg, pld_bytes, last_idx, beat_idx, ipg_cnt;
  logic [2:0]  eop_empty;
  logic        stop_seen;

  logic        strobe, wr_commit, terminate, tx_fire;
  logic [15:0] start_len, start_pld;

  function automatic logic [15:0] clamp_len(input logic [15:0] v);
    if (v < MIN_LEN_C) return MIN_LEN_C;
    if (v > MAX_LEN_C) return MAX_LEN_C;
    return v;
  endfunction

  // Payload beat idx (idx >= 2); bytes at or past nbytes read as zero.
  function automatic logic [63:0] pld_word(input logic [15:0] idx, input logic [15:0] nbytes);
    logic [63:0] w;
    logic [15:0] k;
    w = '0;
    for (int j = 0; j < 8; j++) begin
      k = ((idx - 16'd2) << 3) + 16'(j);
      if (k < nbytes) w[63-8*j -: 8] = k[7:0] ^ SEED;
    end
    return w;
  endfunction

  // Each access is stalled for exactly its first cycle; it completes on the second.
  assign strobe                = avalon_mm_read | avalon_mm_write;
  assign avalon_mm_waitrequest = strobe & ~strobe_d;
  assign wr_commit             = avalon_mm_write & strobe_d;

  assign start_len  = clamp_len(pkt_len);
  assign start_pld  = start_len - 16'd2;
  assign terminate  = stop_seen | ctrl_stop | (~ctrl_cont & (pkt_sent == pkt_numb));
  assign tx_fire    = avalon_st_tx_valid & avalon_st_tx_ready;
  assign gen_active = (state != S_DONE) && (state != S_IDLE);
  assign avalon_st_tx_error = 1'b0;

  // CSR read multiplexer; unmapped addresses and unused bits read zero
  always_comb begin
    csr_rd = '0;
    case (avalon_mm_address)
      8'd0:    csr_rd = da_lo;
      8'd1:    csr_rd = {16'd0, da_hi};
      8'd2:    csr_rd = sa_lo;
      8'd3:    csr_rd = {16'd0, sa_hi};
      8'd4:    csr_rd = pkt_numb;
      8'd5:    csr_rd = {16'd0, pkt_len};
      8'd6:    csr_rd = {29'd0, ctrl_cont, ctrl_stop, ctrl_start};
      8'd7:    csr_rd = {30'd0, gen_active, gen_done};
      8'd8:    csr_rd = pkt_sent;
      default: csr_rd = '0;
    endcase
  end

  // CSR writes, registered read data and start/stop self-clearing pulses
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      strobe_d           <= 1'b0;
      avalon_mm_readdata <= '0;
      da_lo <= '0; da_hi <= '0; sa_lo <= '0; sa_hi <= '0;
      pkt_numb <= '0; pkt_len <= '0;
      ctrl_cont <= 1'b0; ctrl_start <= 1'b0; ctrl_stop <= 1'b0;
    end else begin
      strobe_d   <= strobe;
      ctrl_start <= 1'b0;
      ctrl_stop  <= 1'b0;
      if (avalon_mm_read) avalon_mm_readdata <= csr_rd;
      if (wr_commit) begin
        case (avalon_mm_address)
          8'd0: da_lo    <= avalon_mm_writedata;
          8'd1: da_hi    <= avalon_mm_writedata[15:0];
          8'd2: sa_lo    <= avalon_mm_writedata;
          8'd3: sa_hi    <= avalon_mm_writedata[15:0];
          8'd4: pkt_numb <= avalon_mm_writedata;
          8'd5: pkt_len  <= avalon_mm_writedata[15:0];
          8'd6: begin
            ctrl_cont  <= avalon_mm_writedata[2];
            ctrl_stop  <= avalon_mm_writedata[1];
            ctrl_start <= avalon_mm_writedata[0];
          end
          default: ;
        endcase
      end
    end
  end

  // Frame FSM with registered stream outputs; a beat advances only on valid & ready
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_DONE;
      gen_done <= 1'b1;
      avalon_st_tx_valid <= 1'b0; avalon_st_tx_sop <= 1'b0; avalon_st_tx_eop <= 1'b0;
      avalon_st_tx_data <= '0; avalon_st_tx_empty <= '0;
      seq <= '0; pkt_sent <= '0; len_reg <= '0; pld_bytes <= '0; last_idx <= '0;
      beat_idx <= '0; ipg_cnt <= '0; eop_empty <= '0; stop_seen <= 1'b0;
    end else begin
      if (ctrl_stop) stop_seen <= 1'b1;
      case (state)
        S_DONE: begin
          if (ctrl_start && !ctrl_stop) begin
            state     <= S_IDLE;
            gen_done  <= 1'b0;
            seq       <= '0;
            pkt_sent  <= '0;
            stop_seen <= 1'b0;
            len_reg   <= start_len;
            pld_bytes <= start_pld;
            last_idx  <= 16'd1 + ((start_pld + 16'd7) >> 3);
            eop_empty <= 3'(4'd8 - {1'b0, start_pld[2:0]});
          end
        end
        S_IDLE, S_IPG: begin
          if (state == S_IPG && ipg_cnt != IPG_LAST) begin
            ipg_cnt <= ipg_cnt + 16'd1;
          end else if (terminate) begin
            state    <= S_DONE;
            gen_done <= 1'b1;
          end else begin
            state              <= S_SOP;
            avalon_st_tx_valid <= 1'b1;
            avalon_st_tx_sop   <= 1'b1;
            avalon_st_tx_data  <= {da_hi, da_lo, sa_hi};
            beat_idx           <= '0;
          end
        end
        S_SOP: begin
          if (tx_fire) begin
            state             <= S_HDR1;
            avalon_st_tx_sop  <= 1'b0;
            avalon_st_tx_data <= {sa_lo, len_reg, seq};
            beat_idx          <= 16'd1;
          end
        end
        S_HDR1: begin
          if (tx_fire) begin
            state             <= S_PLD;
            avalon_st_tx_data <= pld_word(16'd2, pld_bytes);
            beat_idx          <= 16'd2;
            if (last_idx == 16'd2) begin
              avalon_st_tx_eop   <= 1'b1;
              avalon_st_tx_empty <= eop_empty;
            end
          end
        end
        S_PLD: begin
          if (tx_fire) begin
            if (avalon_st_tx_eop) begin
              state              <= S_IPG;
              avalon_st_tx_valid <= 1'b0;
              avalon_st_tx_eop   <= 1'b0;
              avalon_st_tx_empty <= '0;
              avalon_st_tx_data  <= '0;
              seq                <= seq + 16'd1;
              pkt_sent           <= pkt_sent + 32'd1;
              ipg_cnt            <= '0;
            end else begin
              beat_idx          <= beat_idx + 16'd1;
              avalon_st_tx_data <= pld_word(beat_idx + 16'd1, pld_bytes);
              if (beat_idx + 16'd1 == last_idx) begin
                avalon_st_tx_eop   <= 1'b1;
                avalon_st_tx_empty <= eop_empty;
              end
            end
          end
        end
        default: state <= S_DONE;
      endcase
    end
  end

endmodule

// File: tb/tb_e10_avl_st_pkt_gen.sv
// Scoreboard bench for e10_avl_st_pkt_gen: stimulus pushes expected beats
// built from a byte-level frame model; a monitor pops them on each transfer.
module tb_e10_avl_st_pkt_gen;

  typedef struct packed {
    logic [63:0] data;
    logic        sop;
    logic        eop;
    logic [2:0]  empty;
    logic        error;
  } beat_t;

  localparam logic [47:0] DA = 48'h0011_2233_4455;
  localparam logic [47:0] SA = 48'h6677_8899_AABB;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [7:0]  mm_address;
  logic        mm_write, mm_read;
  logic [31:0] mm_writedata, readdata;
  logic        waitrequest;
  logic [63:0] tx_data;
  logic        tx_valid, tx_sop, tx_eop, tx_error, tx_ready;
  logic [2:0]  tx_empty;
  logic        gen_active, gen_done;

  beat_t exp_q[$];
  int    n_cmp = 0;
  int    n_fail = 0;
  int    sop_cnt = 0;
  int    n_beats = 0;
  bit    bp_en = 1'b0;

  e10_avl_st_pkt_gen dut (
    .clk                  (clk),
    .reset_n              (reset_n),
    .avalon_mm_address    (mm_address),
    .avalon_mm_write      (mm_write),
    .avalon_mm_read       (mm_read),
    .avalon_mm_writedata  (mm_writedata),
    .avalon_mm_readdata   (readdata),
    .avalon_mm_waitrequest(waitrequest),
    .avalon_st_tx_data    (tx_data),
    .avalon_st_tx_valid   (tx_valid),
    .avalon_st_tx_sop     (tx_sop),
    .avalon_st_tx_eop     (tx_eop),
    .avalon_st_tx_empty   (tx_empty),
    .avalon_st_tx_error   (tx_error),
    .avalon_st_tx_ready   (tx_ready),
    .gen_active           (gen_active),
    .gen_done             (gen_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Expected beats of one frame, built byte by byte
  task automatic push_frame(input int len_csr, input logic [15:0] seq);
    logic [7:0]  b[$];
    logic [15:0] l16;
    int    l, pad, nw;
    beat_t bt;
    l = (len_csr < 46) ? 46 : (len_csr > 1500) ? 1500 : len_csr;
    l16 = 16'(l);
    for (int i = 5; i >= 0; i--) b.push_back(DA[8*i +: 8]);
    for (int i = 5; i >= 0; i--) b.push_back(SA[8*i +: 8]);
    b.push_back(l16[15:8]); b.push_back(l16[7:0]);
    b.push_back(seq[15:8]); b.push_back(seq[7:0]);
    for (int k = 0; k < l - 2; k++) b.push_back(8'(k) ^ 8'h5A);
    pad = (8 - (b.size() % 8)) % 8;
    for (int i = 0; i < pad; i++) b.push_back(8'h00);
    nw = b.size() / 8;
    for (int w = 0; w < nw; w++) begin
      bt.data = '0;
      for (int j = 0; j < 8; j++) bt.data[63-8*j -: 8] = b[8*w+j];
      bt.sop   = (w == 0);
      bt.eop   = (w == nw - 1);
      bt.empty = (w == nw - 1) ? 3'(pad) : 3'd0;
      bt.error = 1'b0;
      exp_q.push_back(bt);
    end
  endtask

  task automatic csr_write(input logic [7:0] a, input logic [31:0] d);
    @(posedge clk); #1;
    mm_address = a; mm_writedata = d; mm_write = 1'b1;
    @(negedge clk); chk("wr_waitreq_first", 64'(waitrequest), 64'd1);
    @(posedge clk); #1;
    @(negedge clk); chk("wr_waitreq_second", 64'(waitrequest), 64'd0);
    @(posedge clk); #1;
    mm_write = 1'b0;
  endtask

  task automatic csr_read(input logic [7:0] a, input logic [31:0] exp, input string name);
    @(posedge clk); #1;
    mm_address = a; mm_read = 1'b1;
    @(negedge clk); chk("rd_waitreq_first", 64'(waitrequest), 64'd1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("rd_waitreq_second", 64'(waitrequest), 64'd0);
    chk(name, 64'(readdata), 64'(exp));
    @(posedge clk); #1;
    mm_read = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    bit ok = 1'b0;
    repeat (3) @(posedge clk);
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      if (gen_done) begin ok = 1'b1; break; end
    end
    chk({name, "_done_in_time"}, 64'(ok), 64'd1);
    repeat (2) @(negedge clk);
    chk({name, "_queue_drained"}, 64'(exp_q.size()), 64'd0);
  endtask

  // Ready driver: always ready, or 50% random backpressure
  initial begin
    tx_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      tx_ready = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Monitor: pops on every transfer, checks stall stability, frame gaps and IPG
  initial begin
    beat_t act, held, exp;
    bit    held_v = 1'b0;
    bit    in_frame = 1'b0;
    int    gap = 99;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        held_v = 1'b0; in_frame = 1'b0; gap = 99;
        continue;
      end
      act = '{data: tx_data, sop: tx_sop, eop: tx_eop, empty: tx_empty, error: tx_error};
      if (held_v) chk("stall_hold", {63'd0, tx_valid} ^ 64'(act != held), 64'd1);
      held_v = 1'b0;
      if (in_frame) chk("valid_in_frame", 64'(tx_valid), 64'd1);
      if (tx_valid) begin
        if (act.sop && gap < 10) begin
          chk("ipg_idle_cycles", 64'(gap), 64'd2);
          gap = 99;
        end
        if (tx_ready) begin
          n_cmp++;
          if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL beat_unexpected: got data=%h sop=%0b eop=%0b empty=%0d, expected no beat",
                     act.data, act.sop, act.eop, act.empty);
          end else begin
            exp = exp_q.pop_front();
            if (act !== exp) begin
              n_fail++;
              $display("FAIL beat: got data=%h sop=%0b eop=%0b empty=%0d err=%0b expected data=%h sop=%0b eop=%0b empty=%0d err=%0b",
                       act.data, act.sop, act.eop, act.empty, act.error,
                       exp.data, exp.sop, exp.eop, exp.empty, exp.error);
            end
          end
          n_beats++;
          if (act.sop) begin sop_cnt++; in_frame = 1'b1; end
          if (act.eop) begin in_frame = 1'b0; gap = 0; end
        end else begin
          held = act; held_v = 1'b1;
        end
      end else if (gap < 99) begin
        gap++;
      end
    end
  end

  // Global time limit
  initial begin
    #2000000;
    $display("FAIL timeout: simulation still running, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    int  base;
    bit  ok, saw_low;
    reset_n = 1'b0; mm_address = '0; mm_write = 1'b0; mm_read = 1'b0; mm_writedata = '0;
    repeat (3) @(posedge clk); #1;
    reset_n = 1'b1;

    // Reset state
    @(negedge clk);
    chk("rst_valid", 64'(tx_valid), 64'd0);
    chk("rst_sop_eop_empty", {59'd0, tx_sop, tx_eop, tx_empty}, 64'd0);
    chk("rst_gen_done", 64'(gen_done), 64'd1);
    chk("rst_gen_active", 64'(gen_active), 64'd0);
    chk("rst_readdata", 64'(readdata), 64'd0);
    csr_read(8'd7, 32'd1, "rst_stat");

    // Test 1: three 64-byte frames, full-rate ready
    csr_write(8'd0, DA[31:0]);
    csr_write(8'd1, 32'hABCD_0000 | 32'(DA[47:32]));
    csr_write(8'd2, SA[31:0]);
    csr_write(8'd3, 32'(SA[47:32]));
    csr_write(8'd4, 32'd3);
    csr_write(8'd5, 32'd64);
    csr_read(8'd0, DA[31:0], "rb_da_lo");
    csr_read(8'd1, 32'h0000_0011, "rb_da_hi_masked");
    csr_read(8'd3, 32'h0000_6677, "rb_sa_hi");
    csr_read(8'd5, 32'd64, "rb_pkt_len");
    csr_read(8'd9, 32'd0, "rb_unmapped");
    for (int s = 0; s < 3; s++) push_frame(64, 16'(s));
    csr_write(8'd6, 32'd1);
    wait_done("t1", 2000);
    csr_read(8'd8, 32'd3, "t1_pkt_sent");
    csr_read(8'd7, 32'd1, "t1_stat");
    csr_read(8'd6, 32'd0, "t1_ctrl_selfclear");

    // Test 2: length clamping at both ends
    csr_write(8'd4, 32'd1);
    csr_write(8'd5, 32'd10);
    push_frame(10, 16'd0);
    csr_write(8'd6, 32'd1);
    wait_done("t2_min", 2000);
    csr_write(8'd5, 32'd2000);
    push_frame(2000, 16'd0);
    csr_write(8'd6, 32'd1);
    wait_done("t2_max", 4000);
    csr_read(8'd5, 32'd2000, "t2_raw_len_kept");

    // Test 3: test 1 under random backpressure
    csr_write(8'd4, 32'd3);
    csr_write(8'd5, 32'd64);
    for (int s = 0; s < 3; s++) push_frame(64, 16'(s));
    bp_en = 1'b1;
    csr_write(8'd6, 32'd1);
    wait_done("t3", 5000);
    bp_en = 1'b0;
    csr_read(8'd8, 32'd3, "t3_pkt_sent");

    // Test 4: continuous run, stop during the sixth frame
    for (int s = 0; s < 6; s++) push_frame(64, 16'(s));
    base = sop_cnt;
    csr_write(8'd6, 32'd5);
    ok = 1'b0;
    for (int c = 0; c < 2000; c++) begin
      @(negedge clk);
      if (sop_cnt == base + 6) begin ok = 1'b1; break; end
    end
    chk("t4_sixth_sop_seen", 64'(ok), 64'd1);
    csr_write(8'd6, 32'd2);
    wait_done("t4", 2000);
    csr_read(8'd8, 32'd6, "t4_pkt_sent");
    csr_read(8'd7, 32'd1, "t4_stat");

    // start and stop together: nothing happens, PKT_SENT untouched
    csr_write(8'd6, 32'd3);
    repeat (6) @(negedge clk);
    chk("startstop_gen_done", 64'(gen_done), 64'd1);
    csr_read(8'd8, 32'd6, "startstop_pkt_sent");

    // Test 5: PKT_NUMB=0 sends nothing, gen_done back within 3 cycles
    csr_write(8'd4, 32'd0);
    csr_write(8'd6, 32'd1);
    saw_low = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (!gen_done) saw_low = 1'b1;
    end
    chk("t5_gen_done_dropped", 64'(saw_low), 64'd1);
    chk("t5_gen_done_back", 64'(gen_done), 64'd1);
    repeat (10) @(negedge clk);
    chk("t5_no_beats", 64'(exp_q.size()), 64'd0);
    csr_read(8'd8, 32'd0, "t5_pkt_sent");

    // Test 6: asynchronous reset in the middle of the payload
    csr_write(8'd4, 32'd1);
    csr_write(8'd5, 32'd1500);
    push_frame(1500, 16'd0);
    base = n_beats;
    csr_write(8'd6, 32'd1);
    ok = 1'b0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (n_beats >= base + 6) begin ok = 1'b1; break; end
    end
    chk("t6_reached_payload", 64'(ok), 64'd1);
    @(posedge clk); #2;
    reset_n = 1'b0;
    #1;
    chk("t6_valid_drops_async", 64'(tx_valid), 64'd0);
    exp_q.delete();
    repeat (2) @(posedge clk); #1;
    reset_n = 1'b1;
    @(negedge clk);
    chk("t6_gen_done", 64'(gen_done), 64'd1);
    chk("t6_valid_low", 64'(tx_valid), 64'd0);
    csr_read(8'd0, 32'd0, "t6_da_lo");
    csr_read(8'd4, 32'd0, "t6_pkt_numb");
    csr_read(8'd5, 32'd0, "t6_pkt_len");
    csr_read(8'd8, 32'd0, "t6_pkt_sent");
    csr_read(8'd7, 32'd1, "t6_stat");
    repeat (5) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
